// File: rtl/adsr_pkg.sv
// adsr_pkg: shared state encodings and width defaults
// for the per-voice ADSR envelope generator.
package adsr_pkg;

  localparam int LEVEL_W_DEF = 16;
  localparam int RATE_W_DEF  = 27;

  localparam logic [LEVEL_W_DEF-1:0] LEVEL_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/adsr_prescaler.sv
// adsr_prescaler: rate counter producing a one-cycle step
// pulse whenever the count reaches the selected rate.
module adsr_prescaler
  import adsr_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);

  logic [RATE_W-1:0] count;

  // Rate is compared live so lowering it fires immediately.
  assign step = en && (count >= rate);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr || step) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: five-state ADSR level generator.
// Optional legato retrigger enabled by ADSR_RETRIGGER_EN.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int RATE_W  = RATE_W_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [RATE_W-1:0]  attack,
  input  logic [RATE_W-1:0]  decay,
  input  logic [RATE_W-1:0]  fade,
  input  logic [LEVEL_W-1:0] sustain,
  input  logic               trigger,
  output logic [LEVEL_W-1:0] level_o,
  output logic [2:0]         state_o,
  output logic               active_o
);

`ifdef ADSR_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [LEVEL_W-1:0] FULL = '1;

  adsr_state_e        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] lvl_inc, lvl_dec;
  logic [RATE_W-1:0]  rate;
  logic               trigger_q, active_q;
  logic               rise, fall, step, en, clr;

  assign rise = trigger & ~trigger_q;
  assign fall = ~trigger & trigger_q;

  assign lvl_inc = (level_q == FULL) ? FULL : level_q + 1'b1;
  assign lvl_dec = (level_q == '0) ? '0 : level_q - 1'b1;

  assign en  = (state_q == S_ATTACK) ||
               (state_q == S_DECAY)  ||
               (state_q == S_RELEASE);
  assign clr = (state_d != state_q);

  always_comb begin
    unique case (state_q)
      S_ATTACK: rate = attack;
      S_DECAY:  rate = decay;
      default:  rate = fade;
    endcase
  end

  adsr_prescaler #(
    .RATE_W (RATE_W)
  ) u_presc (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (clr),
    .en       (en),
    .rate     (rate),
    .step     (step)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      S_IDLE: begin
        level_d = '0;
        if (rise) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (step) begin
          level_d = lvl_inc;
          if (lvl_inc == FULL) state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (rise && RETRIG) begin
          state_d = S_ATTACK;
        end else if (level_q <= sustain) begin
          level_d = sustain;
          state_d = S_SUSTAIN;
        end else if (step) begin
          // A step landing on sustain settles immediately.
          level_d = lvl_dec;
          if (lvl_dec <= sustain) state_d = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (rise && RETRIG) begin
          state_d = S_ATTACK;
        end else begin
          level_d = sustain;
        end
      end
      S_RELEASE: begin
        if (rise) begin
          state_d = S_ATTACK;
        end else if (level_q == '0) begin
          state_d = S_IDLE;
        end else if (step) begin
          level_d = lvl_dec;
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      level_q   <= '0;
      trigger_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      trigger_q <= trigger;
      active_q  <= (state_d != S_IDLE);
    end
  end

  assign level_o  = level_q;
  assign state_o  = state_q;
  assign active_o = active_q;

endmodule
